// File: rtl/psoc_audio_pkg.sv
// rtl/psoc_audio_pkg.sv - shared register map, bit positions and I2S receive FSM states
`timescale 1ns/1ps
package psoc_audio_pkg;

  // Word offsets decoded from wb_adr_i[3:2]
  localparam logic [1:0] I2S_RX_CTRL   = 2'd0;
  localparam logic [1:0] I2S_RX_STATUS = 2'd1;
  localparam logic [1:0] I2S_RX_DATA   = 2'd2;

  // CTRL fields
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_THRESH_LSB = 4;
  localparam int CTRL_THRESH_MSB = 8;

  // STATUS fields
  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_LEVEL_MSB = 4;
  localparam int STAT_OVF_BIT   = 8;
  localparam int STAT_EMPTY_BIT = 9;
  localparam int STAT_FULL_BIT  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_L = 2'd1,
    LEFT   = 2'd2,
    RIGHT  = 2'd3
  } i2s_rx_state_e;

endpackage

// File: rtl/psoc_i2s_rx_fifo.sv
// rtl/psoc_i2s_rx_fifo.sv - first-word-fall-through frame FIFO for the I2S receiver
`timescale 1ns/1ps
module psoc_i2s_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  // Storage array: written only when a push is accepted
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush has priority over any push or pop
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/psoc_i2s_rx.sv
// rtl/psoc_i2s_rx.sv - stereo I2S receiver with frame FIFO and Wishbone register slave
`timescale 1ns/1ps
module psoc_i2s_rx
  import psoc_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int THRESH_RST = 8
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        fifo_high,
  input  logic        i2s_sclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdin
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    sclk_sync, lr_sync, sd_sync;
  logic          sclk_q, sclk_rise, lr_smp, sd_smp;
  logic          lr_prev, lr_change;
  i2s_rx_state_e state, state_nxt;
  logic [15:0]   shreg, left_word;
  logic [4:0]    bit_cnt;
  logic          push_r;
  logic [31:0]   push_data;

  logic          en, ovf;
  logic [4:0]    thresh;
  logic          wb_req, wb_wr, wb_rd;
  logic [1:0]    reg_sel;
  logic [31:0]   rdata;
  logic          fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]   fifo_dout;
  logic [LW-1:0] fifo_level;
  logic [4:0]    level5;

  logic          unused_inputs;
  assign unused_inputs = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:9], wb_dat_i[3:2]};

  // Pad synchronizers; lrclk/sdin samples are delayed one stage so they line up with sclk_rise
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      sclk_q    <= 1'b0;
      sclk_rise <= 1'b0;
      lr_smp    <= 1'b0;
      sd_smp    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], i2s_sclk};
      lr_sync   <= {lr_sync[0], i2s_lrclk};
      sd_sync   <= {sd_sync[0], i2s_sdin};
      sclk_q    <= sclk_sync[1];
      sclk_rise <= sclk_sync[1] & ~sclk_q;
      lr_smp    <= lr_sync[1];
      sd_smp    <= sd_sync[1];
    end
  end

  assign lr_change = lr_smp ^ lr_prev;

  // Framing state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // Framing next state: hunt for the 1->0 lrclk edge that opens a left word, then alternate channels
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT_L;
        WAIT_L:  if (sclk_rise && lr_prev && !lr_smp) state_nxt = LEFT;
        LEFT:    if (sclk_rise && lr_change) state_nxt = RIGHT;
        RIGHT:   if (sclk_rise && lr_change) state_nxt = LEFT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Channel shifter: lrclk change is the delay slot (no capture); next 16 bits land MSB first
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      shreg     <= '0;
      left_word <= '0;
      bit_cnt   <= '0;
      lr_prev   <= 1'b0;
      push_r    <= 1'b0;
      push_data <= '0;
    end else begin
      push_r <= 1'b0;
      if (!en || state == IDLE) begin
        shreg     <= '0;
        left_word <= '0;
        bit_cnt   <= '0;
        lr_prev   <= 1'b0;
      end else if (sclk_rise) begin
        lr_prev <= lr_smp;
        if (state == WAIT_L) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else if (lr_change) begin
          if (state == LEFT) begin
            left_word <= shreg;
          end else begin
            push_r    <= 1'b1;
            push_data <= {left_word, shreg};
          end
          shreg   <= '0;
          bit_cnt <= '0;
        end else if (!bit_cnt[4]) begin
          shreg[~bit_cnt[3:0]] <= sd_smp;
          bit_cnt              <= bit_cnt + 5'd1;
        end
      end
    end
  end

  assign wb_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wb_wr      = wb_req & wb_we_i;
  assign wb_rd      = wb_req & ~wb_we_i;
  assign reg_sel    = wb_adr_i[3:2];
  assign fifo_pop   = wb_rd & (reg_sel == I2S_RX_DATA);
  assign fifo_flush = wb_wr & (reg_sel == I2S_RX_CTRL) & wb_dat_i[CTRL_FLUSH_BIT];
  assign level5     = 5'(fifo_level);

  psoc_i2s_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .arstn (arstn),
    .push  (push_r),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (push_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register read mux; an empty DATA read returns 0
  always_comb begin
    rdata = '0;
    case (reg_sel)
      I2S_RX_CTRL: begin
        rdata[CTRL_EN_BIT]                     = en;
        rdata[CTRL_THRESH_MSB:CTRL_THRESH_LSB] = thresh;
      end
      I2S_RX_STATUS: begin
        rdata[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level5;
        rdata[STAT_OVF_BIT]                  = ovf;
        rdata[STAT_EMPTY_BIT]                = fifo_empty;
        rdata[STAT_FULL_BIT]                 = fifo_full;
      end
      I2S_RX_DATA: rdata = fifo_empty ? 32'd0 : fifo_dout;
      default:     rdata = '0;
    endcase
  end

  // Bus handshake, register writes, sticky overflow and the threshold IRQ
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      en        <= 1'b0;
      thresh    <= 5'(THRESH_RST);
      ovf       <= 1'b0;
      fifo_high <= 1'b0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= wb_rd ? rdata : 32'd0;
      if (wb_wr && reg_sel == I2S_RX_CTRL) begin
        en     <= wb_dat_i[CTRL_EN_BIT];
        thresh <= wb_dat_i[CTRL_THRESH_MSB:CTRL_THRESH_LSB];
      end
      if (push_r && fifo_full && !fifo_flush) begin
        ovf <= 1'b1;
      end else if (wb_wr && reg_sel == I2S_RX_STATUS && wb_dat_i[STAT_OVF_BIT]) begin
        ovf <= 1'b0;
      end
      fifo_high <= (thresh == 5'd0) || (level5 >= thresh);
    end
  end

endmodule

// File: doc/psoc_i2s_rx.md
# psoc_i2s_rx

Stereo I2S receiver: the capture-side counterpart of `psoc_audio`'s I2S transmitter. It samples serial audio from an external ADC or codec, assembles 16-bit left/right frames, and buffers them in a FIFO. The CPU reads the frames over the same Wishbone slave bus `psoc_audio` uses. It sits beside `psoc_audio` in `soc_top` and raises `fifo_high` into a spare neorv32 fast-IRQ input.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: stereo frames buffered; power of two, 2..16.
- `THRESH_RST`, 8: reset value of the `fifo_high` threshold.

Ports:
- `clk` in 1: system clock, the only clock.
- `arstn` in 1: asynchronous, active-low reset.
- `wb_adr_i` in 32: byte address; only `[3:2]` is decoded.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_we_i` in 1: write enable.
- `wb_sel_i` in 4: byte lanes; ignored, all writes are full-word.
- `wb_stb_i` in 1: strobe.
- `wb_cyc_i` in 1: cycle.
- `wb_ack_o` out 1: acknowledge.
- `fifo_high` out 1: level-sensitive IRQ, asserted while FIFO level ≥ `THRESH`.
- `i2s_sclk` in 1: bit clock. Asynchronous to `clk`; maximum frequency is `clk`/4.
- `i2s_lrclk` in 1: word select; 0 = left, 1 = right.
- `i2s_sdin` in 1: serial data, MSB first.

## Operation
- Input capture:
  - `i2s_sclk`, `i2s_lrclk` and `i2s_sdin` each pass through a 2-FF synchronizer.
  - The rising edge of synchronized sclk produces a one-cycle `sclk_rise` pulse.
  - On every `sclk_rise`, sdin and lrclk are sampled.
- Framing:
  - FSM states: `IDLE`, `WAIT_L`, `LEFT`, `RIGHT`.
  - `IDLE`: entered when `EN`=0; shifters and bit counter are cleared.
  - `EN`=1 moves `IDLE` to `WAIT_L`. `WAIT_L` waits for lrclk to sample 1 and then 0 on consecutive `sclk_rise`, then enters `LEFT`.
  - The `sclk_rise` on which lrclk changes is the I2S delay slot. The bit counter resets to 0 there and no bit is captured.
  - The next 16 `sclk_rise` shift sdin into the channel shifter MSB first. Further slots are ignored, so word lengths >16 are truncated.
  - A 0→1 lrclk change moves `LEFT` to `RIGHT` and latches the left word.
  - A 1→0 change moves `RIGHT` to `LEFT` and completes the frame. The FIFO push is `{left[15:0], right[15:0]}`.
  - If an lrclk change arrives before 16 bits have been captured, the short word is zero-padded in its LSBs and still used.
- FIFO:
  - Push when the FIFO is full: the frame is dropped and the sticky `OVF` bit is set. The FIFO contents are untouched.
  - Pop on a DATA read when the FIFO is not empty.
  - A simultaneous push and pop both take effect; the level is unchanged.
- Registers, at `wb_adr_i[3:2]`:
  - 0 `CTRL` (RW): `[0]` EN (reset 0); `[1]` FLUSH, write-1 empties the FIFO and reads back 0; `[8:4]` THRESH (reset `THRESH_RST`).
  - 1 `STATUS`: `[4:0]` level (RO); `[8]` OVF (write 1 to clear); `[9]` empty (RO); `[10]` full (RO).
  - 2 `DATA` (RO): a read pops one frame. Reading while empty returns 0 with no pop and no error.
  - 3: reads 0; writes are ignored.
  - Writes to RO bits are ignored.
- Clearing `EN` returns the FSM to `IDLE`. Any partial frame is discarded and the FIFO is kept.
- If FLUSH and a push occur in the same cycle, FLUSH wins: the level becomes 0.

## Timing
- Reset values: `wb_dat_o`=0, `wb_ack_o`=0, `fifo_high`=0, FSM=`IDLE`, FIFO empty, OVF=0.
- Wishbone handshake:
  - `wb_ack_o` goes high for exactly one cycle, the cycle after `wb_cyc_i & wb_stb_i & ~wb_ack_o`.
  - `wb_dat_o` is valid in the ack cycle and is 0 otherwise.
  - Register writes and pops take effect at the ack edge.
- Sampling latency: a pad edge reaches `sclk_rise` 3 `clk` cycles later.
- Push latency: the FIFO push happens 1 cycle after the `sclk_rise` that completes the frame.
- `fifo_high` is registered and updates 1 cycle after any level or THRESH change.
- THRESH=0 forces `fifo_high`=1.

## Structure
- Shared package `psoc_audio_pkg`:
  - Register offsets `I2S_RX_CTRL`, `I2S_RX_STATUS`, `I2S_RX_DATA`.
  - CTRL/STATUS bit positions.
  - The FSM state enum.
- Sub-module `psoc_i2s_rx_fifo`:
  - Synchronous FIFO, width 32, depth `FIFO_DEPTH`.
  - Ports: push, pop, flush, dout, level, full, empty.
  - First-word-fall-through, so DATA reads need no extra latency.

## Test plan
- Reset → all outputs 0; a STATUS read returns `0x200`; a CTRL read returns `0x80` (THRESH 8 at `[8:4]`).
- EN=1, then send L=`0xA55A`, R=`0x1234` at sclk = `clk`/8 → level 1; DATA read returns `0xA55A1234`; level returns to 0.
- Enable in the middle of a right word → that partial frame is not pushed; the first DATA read returns the first complete frame sent afterwards.
- THRESH=2: push 2 frames → `fifo_high` rises 1 cycle after the 2nd push; one DATA read → `fifo_high` falls.
- Push 17 frames with depth 16 → full=1, OVF=1; the FIFO holds frames 1..16; writing STATUS `0x100` clears OVF.
- Send 24-bit words `0xFEDCBA`/`0x123456` → read `0xFEDC1234`. A DATA read while empty → returns 0 and level stays 0.
